// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared constants and helpers for CPU inter-stage pipeline registers.
package cpu_pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 118;
  localparam int EXMEM_W = 73;
  localparam int MEMWB_W = 71;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_wrap_ptr.sv
// pipe_wrap_ptr: ring pointer with increment, clear and explicit wrap at DEPTH-1.
module pipe_wrap_ptr #(
  parameter int DEPTH = 2,
  parameter int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-entry valid/ready pipeline register with flush, PC field and occupancy.
module elastic_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               PC_W   = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  localparam int              PW     = PC_W > 0 ? PC_W : 1,
  localparam int              AW     = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int              CW     = cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [PW-1:0]    pc_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [PW-1:0]    pc_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);
  logic [CW-1:0]    count;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]    pc_mem   [DEPTH];
  logic             push, pop, clr;
  assign in_ready_o  = count != CW'(DEPTH);
  assign out_valid_o = count != '0;
  assign clr         = start_i & flush_i;
  assign push        = start_i & in_valid_i & in_ready_o & ~flush_i;
  assign pop         = start_i & out_valid_o & out_ready_i & ~stall_i & ~flush_i;
  assign count_o     = count;
  assign data_o      = out_valid_o ? data_mem[rd_ptr] : BUBBLE;
  assign pc_o        = (out_valid_o && PC_W > 0) ? pc_mem[rd_ptr] : '0;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) count <= '0;
    else if (clr) count <= '0;
    else count <= count + CW'(push) - CW'(pop);
  // storage needs no reset: only entries below count are ever observed
  always_ff @(posedge clk_i)
    if (push) begin
      data_mem[wr_ptr] <= data_i;
      pc_mem[wr_ptr]   <= pc_i;
    end
  pipe_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr (
    .clk_i(clk_i), .rst_i(rst_i), .clr(clr), .inc(push), .ptr(wr_ptr)
  );
  pipe_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd (
    .clk_i(clk_i), .rst_i(rst_i), .clr(clr), .inc(pop), .ptr(rd_ptr)
  );
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: table, directed and random checks of DEPTH=2 and DEPTH=3 instances against a queue model.
module tb_elastic_pipe_reg;
  logic clk = 0, rst_n = 0;
  logic st = 0, iv = 0, ory = 0, stl = 0, fl = 0;
  logic [7:0] din = 0, pc_in = 0;
  logic ir2, ov2, ir3, ov3;
  logic [7:0] do2, pco2, do3, pco3;
  logic [1:0] c2, c3;
  int total = 0, bad = 0;
  logic [15:0] q[2][$];
  int dep[2] = '{2, 3};
  typedef struct {
    logic st, iv;
    logic [7:0] din;
    logic ory, stl, fl, ev;
    logic [7:0] ed;
    logic [1:0] ec;
    logic er;
  } vec_t;
  vec_t tab[27];

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(8), .PC_W(8), .DEPTH(2), .BUBBLE(8'hEE)) u_d2 (
    .clk_i(clk), .rst_i(rst_n), .start_i(st), .in_valid_i(iv), .in_ready_o(ir2),
    .pc_i(pc_in), .data_i(din), .out_valid_o(ov2), .out_ready_i(ory), .stall_i(stl),
    .flush_i(fl), .pc_o(pco2), .data_o(do2), .count_o(c2));
  elastic_pipe_reg #(.WIDTH(8), .PC_W(8), .DEPTH(3), .BUBBLE(8'hEE)) u_d3 (
    .clk_i(clk), .rst_i(rst_n), .start_i(st), .in_valid_i(iv), .in_ready_o(ir3),
    .pc_i(pc_in), .data_i(din), .out_valid_o(ov3), .out_ready_i(ory), .stall_i(stl),
    .flush_i(fl), .pc_o(pco3), .data_o(do3), .count_o(c3));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cmp_dut(input int k, input logic v, input logic [7:0] d, input logic [7:0] p,
                         input logic [1:0] c, input logic r);
    int n = q[k].size();
    logic [15:0] h = (n != 0) ? q[k][0] : 16'h00EE;
    chk($sformatf("m%0d_valid", k), {31'd0, v}, {31'd0, n != 0});
    chk($sformatf("m%0d_data", k), {24'd0, d}, {24'd0, h[7:0]});
    chk($sformatf("m%0d_pc", k), {24'd0, p}, {24'd0, h[15:8]});
    chk($sformatf("m%0d_count", k), {30'd0, c}, n);
    chk($sformatf("m%0d_ready", k), {31'd0, r}, {31'd0, n != dep[k]});
  endtask

  task automatic mcheck();
    cmp_dut(0, ov2, do2, pco2, c2, ir2);
    cmp_dut(1, ov3, do3, pco3, c3, ir3);
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      int n = q[k].size();
      bit pu = st && iv && n != dep[k] && !fl;
      bit po = st && n != 0 && ory && !stl && !fl;
      if (st && fl) q[k].delete();
      else begin
        if (po) void'(q[k].pop_front());
        if (pu) q[k].push_back({pc_in, din});
      end
    end
    @(posedge clk);
    #1;
    mcheck();
  endtask

  initial begin
    tab[0]  = '{1, 1, 8'h0A, 1, 0, 0, 1, 8'h0A, 1, 1};
    tab[1]  = '{1, 1, 8'h0B, 1, 0, 0, 1, 8'h0B, 1, 1};
    tab[2]  = '{1, 1, 8'h0C, 1, 0, 0, 1, 8'h0C, 1, 1};
    tab[3]  = '{1, 0, 8'h00, 1, 0, 0, 0, 8'hEE, 0, 1};
    tab[4]  = '{1, 1, 8'h11, 0, 0, 0, 1, 8'h11, 1, 1};
    tab[5]  = '{1, 1, 8'h22, 0, 0, 0, 1, 8'h11, 2, 0};
    tab[6]  = '{1, 1, 8'h33, 0, 0, 0, 1, 8'h11, 2, 0};
    tab[7]  = '{1, 0, 8'h00, 1, 0, 0, 1, 8'h22, 1, 1};
    tab[8]  = '{1, 0, 8'h00, 1, 0, 0, 0, 8'hEE, 0, 1};
    tab[9]  = '{1, 1, 8'h55, 0, 0, 0, 1, 8'h55, 1, 1};
    tab[10] = '{1, 1, 8'h66, 0, 0, 0, 1, 8'h55, 2, 0};
    tab[11] = '{1, 1, 8'h44, 1, 0, 1, 0, 8'hEE, 0, 1};
    tab[12] = '{1, 0, 8'h44, 1, 0, 0, 0, 8'hEE, 0, 1};
    tab[13] = '{1, 1, 8'h77, 0, 0, 0, 1, 8'h77, 1, 1};
    tab[14] = '{1, 1, 8'h44, 1, 0, 1, 0, 8'hEE, 0, 1};
    tab[15] = '{1, 0, 8'h00, 1, 0, 0, 0, 8'hEE, 0, 1};
    tab[16] = '{1, 1, 8'h88, 0, 0, 0, 1, 8'h88, 1, 1};
    tab[17] = '{1, 0, 8'h00, 1, 1, 0, 1, 8'h88, 1, 1};
    tab[18] = '{1, 0, 8'h00, 1, 1, 0, 1, 8'h88, 1, 1};
    tab[19] = '{1, 0, 8'h00, 1, 1, 0, 1, 8'h88, 1, 1};
    tab[20] = '{0, 1, 8'h99, 1, 0, 0, 1, 8'h88, 1, 1};
    tab[21] = '{1, 0, 8'h00, 1, 0, 0, 0, 8'hEE, 0, 1};
    tab[22] = '{1, 1, 8'h12, 0, 0, 0, 1, 8'h12, 1, 1};
    tab[23] = '{0, 0, 8'h00, 1, 0, 1, 1, 8'h12, 1, 1};
    tab[24] = '{1, 0, 8'h00, 1, 0, 0, 0, 8'hEE, 0, 1};
    tab[25] = '{1, 1, 8'h34, 0, 0, 0, 1, 8'h34, 1, 1};
    tab[26] = '{1, 0, 8'h00, 1, 1, 1, 0, 8'hEE, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, ov2}, 0);
    chk("rst_ready", {31'd0, ir2}, 1);
    chk("rst_count", {30'd0, c2}, 0);
    chk("rst_data", {24'd0, do2}, 32'hEE);
    chk("rst_pc", {24'd0, pco2}, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    mcheck();

    foreach (tab[i]) begin
      st = tab[i].st; iv = tab[i].iv; din = tab[i].din; pc_in = tab[i].din ^ 8'h5A;
      ory = tab[i].ory; stl = tab[i].stl; fl = tab[i].fl;
      cycle();
      chk($sformatf("tab%0d_valid", i), {31'd0, ov2}, {31'd0, tab[i].ev});
      chk($sformatf("tab%0d_data", i), {24'd0, do2}, {24'd0, tab[i].ed});
      chk($sformatf("tab%0d_pc", i), {24'd0, pco2}, tab[i].ev ? {24'd0, tab[i].ed ^ 8'h5A} : 0);
      chk($sformatf("tab%0d_count", i), {30'd0, c2}, {30'd0, tab[i].ec});
      chk($sformatf("tab%0d_ready", i), {31'd0, ir2}, {31'd0, tab[i].er});
    end

    st = 1; stl = 0; fl = 0; ory = 1; iv = 1;
    for (int i = 0; i < 10; i++) begin
      din = 8'(i); pc_in = 8'(i) ^ 8'h5A;
      cycle();
      chk($sformatf("wrap%0d_data", i), {24'd0, do3}, i);
      chk($sformatf("wrap%0d_count", i), {30'd0, c3}, 1);
    end
    iv = 0;
    cycle();
    chk("wrap_empty", {31'd0, ov3}, 0);

    iv = 1; ory = 0; din = 8'hC1; pc_in = 8'h1C;
    cycle();
    din = 8'hC2; pc_in = 8'h2C;
    cycle();
    #2;
    rst_n = 0;
    #1;
    q[0].delete();
    q[1].delete();
    chk("arst_count3", {30'd0, c3}, 0);
    chk("arst_data3", {24'd0, do3}, 32'hEE);
    mcheck();
    iv = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    mcheck();

    for (int i = 0; i < 600; i++) begin
      st = $urandom_range(0, 9) != 0;
      iv = $urandom_range(0, 3) != 0;
      din = 8'($urandom);
      pc_in = 8'($urandom);
      ory = $urandom_range(0, 2) != 0;
      stl = $urandom_range(0, 5) == 0;
      fl = $urandom_range(0, 24) == 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It is a DEPTH-entry elastic stage carrying a PC field and a WIDTH-bit payload. It adds valid/ready handshaking, buffering for decoupled stages (e.g. future I-cache/D-cache miss stalls), synchronous flush with bubble insertion, and an occupancy count. It drops in between any two CPU stages.

Parameters:
WIDTH, 32, payload width in bits (1..256)
PC_W, 32, PC field width (0 legal: pc ports unused, tied 0)
DEPTH, 2, number of buffered entries (1..16, need not be a power of two)
BUBBLE, 0, payload value driven on data_o when empty or after flush

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  global run enable; low freezes all state
in_valid_i  in  1  upstream entry valid
in_ready_o  out  1  stage can accept an entry this cycle
pc_i  in  PC_W  upstream PC
data_i  in  WIDTH  upstream payload
out_valid_o  out  1  head entry valid
out_ready_i  in  1  downstream consumes head this cycle
stall_i  in  1  hazard stall; blocks pop, same effect as out_ready_i=0
flush_i  in  1  synchronous flush (branch taken / exception)
pc_o  out  PC_W  head PC (0 when empty)
data_o  out  WIDTH  head payload (BUBBLE when empty)
count_o  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_i=0, async): count=0, read/write pointers=0, out_valid_o=0, data_o=BUBBLE, pc_o=0, in_ready_o=1. Storage contents are don't-care.
- push = start_i & in_valid_i & in_ready_o & ~flush_i.
- pop = start_i & out_valid_o & out_ready_i & ~stall_i & ~flush_i.
- in_ready_o = (count != DEPTH). It depends only on registered state; there is no combinational path from out_ready_i.
- Latency: an entry pushed in cycle N is visible on out_valid_o/data_o in cycle N+1. No same-cycle pass-through.
- out_valid_o = (count != 0). data_o/pc_o show the head entry, or BUBBLE/0 when count=0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready_o=0 and the input is ignored, even if a pop occurs in the same cycle.
- Empty: pop is impossible; out_ready_i is ignored.
- Pointer wrap: pointers run 0..DEPTH-1 and wrap to 0 explicitly, which covers non-power-of-two DEPTH. DEPTH=1 is a single register with a valid bit.
- flush_i=1 (and start_i=1): next cycle count=0, pointers=0, out_valid_o=0, data_o=BUBBLE. Any concurrent push or pop is discarded. Flush has priority over stall_i.
- start_i=0: no push, pop or flush. in_ready_o and out_valid_o still reflect state, but no transfer occurs.
- Reset asserted mid-transfer: immediate return to reset values; no partial entry survives.
- count_o is registered and equals pushes minus pops since the last flush/reset. It never exceeds DEPTH and never underflows.

Decomposition:
- Shared package cpu_pipe_pkg:
  - NOP_INSTR = 32'h00000013, used as BUBBLE for IF/ID instances.
  - Localparam helper for the count width ($clog2(DEPTH+1)).
  - Standard stage payload widths: IFID_W, IDEX_W=118, EXMEM_W=73, MEMWB_W=71.
- One sub-module, pipe_wrap_ptr: a pointer register with increment, clear and wrap-at-DEPTH, instantiated twice (read and write).
- Storage is an unpacked register array inside the top module.

Test Plan:
- Reset/idle, DEPTH=2: hold rst_i=0, then release -> out_valid_o=0, in_ready_o=1, count_o=0, data_o=BUBBLE.
- Streaming, DEPTH=2: push 0xA, 0xB, 0xC on consecutive cycles with out_ready_i=1 -> data_o shows 0xA, 0xB, 0xC in cycles 1-3, count_o stays 1.
- Backpressure, DEPTH=2: out_ready_i=0, push 0x11, 0x22, 0x33 -> count_o=2, in_ready_o=0, 0x33 not accepted. Then out_ready_i=1 -> outputs 0x11 then 0x22, then empty.
- Flush during push: count_o=2, assert flush_i together with in_valid_i and data 0x44 -> next cycle count_o=0, out_valid_o=0, data_o=BUBBLE, and 0x44 never appears.
- Stall and start: with count_o=1, stall_i=1 and out_ready_i=1 for 3 cycles -> head held, count_o=1. With start_i=0 plus a push -> count_o unchanged.
- Wrap, DEPTH=3: 10 push/pop pairs of incrementing data -> in-order output 0..9 across the non-power-of-two wrap. Async reset asserted mid-stream -> outputs at reset values immediately.
